// File: rtl/byte_serial_adder.sv
// Multi-byte adder: sums two NUM_BYTES-wide operands one byte per clock, LSB first.
// Optional macro BYTE_SERIAL_SUB_EN adds an in_sub port that turns the operation into A-B.
module byte_serial_adder #(
  parameter int unsigned NUM_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_a,
  input  logic [8*NUM_BYTES-1:0] in_b,
`ifdef BYTE_SERIAL_SUB_EN
  input  logic                   in_sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_sum,
  output logic                   out_carry,
  output logic                   busy
);

  localparam int unsigned W    = 8 * NUM_BYTES;
  localparam int unsigned IdxW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d, cout_q, cout_d;
  logic            sub_q, sub_d, sub_in;
  logic [7:0]      a_byte, b_byte;
  logic [8:0]      add9;

`ifdef BYTE_SERIAL_SUB_EN
  assign sub_in = in_sub;
`else
  assign sub_in = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    a_byte  = a_q[{idx_q, 3'b000} +: 8];
    // Subtraction is A + ~B + 1: invert B bytes, seed the carry with 1.
    b_byte  = b_q[{idx_q, 3'b000} +: 8] ^ {8{sub_q}};
    add9    = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, carry_q};
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          sub_d   = sub_in;
          carry_d = sub_in;
          idx_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        sum_d[{idx_q, 3'b000} +: 8] = add9[7:0];
        carry_d = add9[8];
        if (idx_q == LastIdx) begin
          // Park the index at 0 so it never points past the top byte.
          idx_d   = '0;
          cout_d  = add9[8];
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_sum   = sum_q;
  assign out_carry = cout_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Directed bench for byte_serial_adder: scoreboard queue of expected results, immediate asserts.
module tb_byte_serial_adder;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         carry;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, out_carry, busy;
  logic [W-1:0] in_a, in_b, out_sum;
`ifdef BYTE_SERIAL_SUB_EN
  logic         in_sub;
`endif

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  byte_serial_adder #(.NUM_BYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef BYTE_SERIAL_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation: accept, latency check, optional stall with a rejected offer, then handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input int stall);
    logic [W:0] full;
    exp_t       e;
    exp_t       got;
    logic [W-1:0] held_sum;
    logic         held_carry;
    full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{W{1'b0}}, sub};
    e.sum   = full[W-1:0];
    e.carry = full[W];
    exp_q.push_back(e);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
`ifdef BYTE_SERIAL_SUB_EN
    in_sub   = sub;
`endif
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    in_a     = $urandom();
    in_b     = $urandom();
    for (int k = 1; k <= NB; k++) begin
      check("in_ready_low", 64'(in_ready), 64'd0);
      check("busy_high", 64'(busy), 64'd1);
      tick();
      check($sformatf("out_valid_at_%0d", k), 64'(out_valid), 64'(k == NB));
    end
    held_sum   = out_sum;
    held_carry = out_carry;
    for (int s = 0; s < stall; s++) begin
      // A different operand offered during the stall must be ignored.
      in_valid = 1'b1;
      in_a     = ~a;
      in_b     = 32'h0F0F_0F0F;
      tick();
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_sum", 64'(out_sum), 64'(held_sum));
      check("stall_carry", 64'(out_carry), 64'(held_carry));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 64'd1, 64'd0);
      end else begin
        got = exp_q.pop_front();
        check("out_sum", 64'(out_sum), 64'(got.sum));
        check("out_carry", 64'(out_carry), 64'(got.carry));
      end
    end
    tick();
    check("post_valid", 64'(out_valid), 64'd0);
    check("post_in_ready", 64'(in_ready), 64'd1);
    check("post_sum_kept", 64'(out_sum), 64'(e.sum));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
`ifdef BYTE_SERIAL_SUB_EN
    in_sub    = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_carry", 64'(out_carry), 64'd0);

    run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 0);
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'h5555_5555, 32'h3333_3333, 1'b0, 3);
    run_op(32'h89AB_CDEF, 32'h7654_3211, 1'b0, 0);

    // Reset during the second ADD cycle aborts the operation.
    in_valid = 1'b1;
    in_a     = 32'h1234_5678;
    in_b     = 32'h1111_1111;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out_sum", 64'(out_sum), 64'd0);
    check("abort_out_carry", 64'(out_carry), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_valid", 64'(out_valid), 64'd0);
    end
    run_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 0);

`ifdef BYTE_SERIAL_SUB_EN
    run_op(32'h0000_0000, 32'h0000_0001, 1'b1, 0);
    run_op(32'h0000_0005, 32'h0000_0003, 1'b1, 1);
    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0);
`endif

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
